register_file_scoreboarded: RTL
===============================

// Module: register_file_scoreboarded
// PURPOSE
// - Parametrised successor to the Frost32 3-read/1-write register file.
// - Configurable read/write port counts, registered (1-cycle) reads with
//   same-cycle write bypass, and an optional hardwired-zero r0.
// - Per-register pending scoreboard: reserve on issue, clear on writeback.
// - Post-reset clear sequencer; sits between decode (reads/reserve) and writeback.
// PARAMETERS
// - DATA_WIDTH       32  register width in bits
// - NUM_REGS         16  register count; power of 2, >= 2; SEL_W = $clog2(NUM_REGS)
// - NUM_READ_PORTS    3  read ports (ra, rb, rc in the Frost32 core)
// - NUM_WRITE_PORTS   2  write ports; a higher index wins on a same-register collision
// - ZERO_REG          1  1: r0 always reads 0; writes/reserves to r0 are dropped
// PORTS
// - clk            in   1                      clock; all state changes on the rising edge
// - rst_n          in   1                      synchronous reset, active-low
// - ready          out  1                      1 once the clear sequence is done
// - read_sel       in   NUM_READ_PORTS*SEL_W   port p uses slice [p*SEL_W +: SEL_W]
// - read_data      out  NUM_READ_PORTS*DATA_WIDTH  registered data per port
// - read_pending   out  NUM_READ_PORTS         registered pending bit per port
// - write_en       in   NUM_WRITE_PORTS        per-port write enable
// - write_sel      in   NUM_WRITE_PORTS*SEL_W  per-port destination
// - write_data     in   NUM_WRITE_PORTS*DATA_WIDTH  per-port data
// - reserve_en     in   1                      mark reserve_sel pending
// - reserve_sel    in   SEL_W                  register to reserve
// BEHAVIOUR
// - Reset (rst_n=0 at an edge):
//   - state <= INIT, clr_cnt <= 0, ready <= 0.
//   - read_data <= 0, read_pending <= 0, every pending bit <= 0.
//   - Reset mid-INIT or mid-READY restarts the sequence from clr_cnt 0.
// - FSM INIT:
//   - Each cycle: regs[clr_cnt] <= 0, clr_cnt++.
//   - When clr_cnt == NUM_REGS-1: that cycle clears the last register and
//     state <= READY, ready <= 1.
//   - INIT lasts exactly NUM_REGS cycles.
// - While in INIT:
//   - write_en and reserve_en are ignored.
//   - read_data <= 0, read_pending <= 0.
// - FSM READY: terminal state until reset.
// - Writes (READY):
//   - For each port w with write_en[w]: regs[write_sel_w] <= write_data_w.
//   - Same register from several ports: highest-index port's data lands.
// - Reads (READY), 1-cycle latency: read_data_p <= value of regs[read_sel_p]
//   after this edge's writes. The data source is chosen in this order:
//   - ZERO_REG && sel == 0: 0.
//   - Otherwise, if any enabled write targets sel this cycle: the
//     highest-index such write_data (bypass).
//   - Otherwise: regs[sel].
// - Scoreboard (READY), applied per edge:
//   - Writes: pending[write_sel_w] <= 0 for every enabled w.
//   - Then reserve: if reserve_en, pending[reserve_sel] <= 1; reserve beats a
//     same-cycle write to the same register.
//   - ZERO_REG: pending[0] is constant 0.
// - read_pending_p <= pending[read_sel_p] as updated at this edge. A read that
//   coincides with its register's writeback therefore reports 0, unless
//   reserved in that same cycle.
// - A write to a non-pending register is legal; it updates data, pending stays 0.
// - Reserving an already-pending register is legal; it stays 1.
// - No X propagation: unused slices are still driven per the rules above.
// TESTING
// 1. Reset held 3 cycles, then released.
//    -> ready=0 for exactly 16 cycles, then 1; read_data=0 throughout.
// 2. READY: write r5=0xDEADBEEF on port0, read r5 next cycle.
//    -> read_data (read port 0) = 0xDEADBEEF one cycle after the read_sel cycle.
// 3. Bypass: same cycle, write r3=0x12345678 and read_sel port1=r3.
//    -> next cycle read_data (read port 1) = 0x12345678.
// 4. Collision: port0 r7=0x1, port1 r7=0x2 in one cycle.
//    -> later read of r7 = 0x2.
// 5. Zero reg: write r0=0xFFFFFFFF and reserve r0.
//    -> read r0 = 0, read_pending = 0.
// 6. Scoreboard: reserve r9; read r9 -> pending 1.
//    - Same cycle: write r9 and reserve r9 -> pending stays 1.
//    - Then write-only r9 -> read shows pending 0, new data.
// 7. Reset asserted at clr_cnt=8 of INIT.
//    -> sequence restarts; ready rises 16 cycles after release.

Source files
------------

// File: rtl/register_file_scoreboarded_if.sv
// Decode/writeback-facing bundle of the scoreboarded register file.
// The master side issues reads, reserves and writebacks; the slave side is the register file.
interface register_file_scoreboarded_if #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_REGS        = 16,
    parameter int unsigned NUM_READ_PORTS  = 3,
    parameter int unsigned NUM_WRITE_PORTS = 2
);
    localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                                  ready;
    logic [NUM_READ_PORTS*SEL_W-1:0]       read_sel;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  read_data;
    logic [NUM_READ_PORTS-1:0]             read_pending;
    logic [NUM_WRITE_PORTS-1:0]            write_en;
    logic [NUM_WRITE_PORTS*SEL_W-1:0]      write_sel;
    logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data;
    logic                                  reserve_en;
    logic [SEL_W-1:0]                      reserve_sel;

    modport master (
        input  ready, read_data, read_pending,
        output read_sel, write_en, write_sel, write_data, reserve_en, reserve_sel
    );

    modport slave (
        output ready, read_data, read_pending,
        input  read_sel, write_en, write_sel, write_data, reserve_en, reserve_sel
    );
endinterface

// File: rtl/register_file_scoreboarded.sv
// Multi-port register file with registered reads, write bypass, optional hardwired r0
// and a per-register pending scoreboard; clears itself one register per cycle after reset.
module register_file_scoreboarded #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_REGS        = 16,
    parameter int unsigned NUM_READ_PORTS  = 3,
    parameter int unsigned NUM_WRITE_PORTS = 2,
    parameter bit          ZERO_REG        = 1'b1
) (
    input logic                        clk,
    input logic                        rst_n,
    register_file_scoreboarded_if.slave bus
);
    localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {StInit, StReady} state_e;

    state_e                               state_q, state_d;
    logic [SEL_W-1:0]                     clr_cnt_q, clr_cnt_d;
    logic                                 ready_q, ready_d;
    logic [DATA_WIDTH-1:0]                regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]                regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]                  pending_q, pending_d;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic [NUM_READ_PORTS-1:0]            read_pending_q, read_pending_d;
    logic [SEL_W-1:0]                     wsel, rsel;

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        regs_d         = regs_q;
        pending_d      = pending_q;
        read_data_d    = '0;
        read_pending_d = '0;
        wsel           = '0;
        rsel           = '0;

        if (state_q == StInit) begin
            regs_d[clr_cnt_q] = '0;
            clr_cnt_d         = clr_cnt_q + SEL_W'(1);
            if (clr_cnt_q == SEL_W'(NUM_REGS - 1)) begin
                state_d = StReady;
            end
        end else begin
            // Ascending port order lets the highest-index write win a collision.
            for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                if (bus.write_en[w]) begin
                    wsel            = bus.write_sel[w*SEL_W +: SEL_W];
                    regs_d[wsel]    = bus.write_data[w*DATA_WIDTH +: DATA_WIDTH];
                    pending_d[wsel] = 1'b0;
                end
            end
            if (bus.reserve_en) begin
                pending_d[bus.reserve_sel] = 1'b1;
            end
            if (ZERO_REG) begin
                regs_d[0]    = '0;
                pending_d[0] = 1'b0;
            end

            // Reading the next-state arrays gives the same-cycle write bypass for free.
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                rsel = bus.read_sel[p*SEL_W +: SEL_W];
                read_data_d[p*DATA_WIDTH +: DATA_WIDTH] =
                    (ZERO_REG && rsel == '0) ? '0 : regs_d[rsel];
                read_pending_d[p] = pending_d[rsel];
            end
        end

        ready_d = (state_d == StReady);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StInit;
            clr_cnt_q      <= '0;
            ready_q        <= 1'b0;
            pending_q      <= '0;
            read_data_q    <= '0;
            read_pending_q <= '0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            ready_q        <= ready_d;
            pending_q      <= pending_d;
            read_data_q    <= read_data_d;
            read_pending_q <= read_pending_d;
        end
    end

    // Storage has no reset of its own; the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            regs_q <= regs_d;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.read_data    = read_data_q;
    assign bus.read_pending = read_pending_q;
endmodule
